// File: rtl/adc_frame_packer_if.sv
// UDP TX streaming bus between the frame packer (master) and the UDP TX core (slave).
interface adc_frame_packer_if;
  logic        udp_rd_en;
  logic        udp_tx_req;
  logic [31:0] udp_tx_data;

  modport master (input udp_rd_en, output udp_tx_req, output udp_tx_data);
  modport slave  (output udp_rd_en, input udp_tx_req, input udp_tx_data);
endinterface

// File: rtl/adc_frame_packer.sv
// ADC frame packer: baseline-subtracts and saturates each channel of an accepted
// ADC frame, tags it with channel index and frame count, buffers the words in a
// 32-bit FIFO and streams one UDP packet's worth of words on read strobes.
module adc_frame_packer #(
  parameter int ADC_CHANEL = 20,
  parameter int DATAWIDTH  = 16,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                            rib_clk,
  input  logic                            rib_rst_n,
  input  logic [ADC_CHANEL*DATAWIDTH-1:0] adc_value,
  input  logic                            adc_valid,
  input  logic [ADC_CHANEL*DATAWIDTH-1:0] baseline_rib_data,
  input  logic                            cfg_fifo_wr_en,
  input  logic                            cfg_udp_tx_enable,
  input  logic [15:0]                     cfg_tx_data_num,
  adc_frame_packer_if.master              udp,
  output logic [ADDR_W:0]                 fifo_level,
  output logic [15:0]                     frame_cnt,
  output logic [15:0]                     drop_cnt,
  output logic                            packer_busy
);

  localparam int LW = ADDR_W + 1;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_PACK = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_SEND = 2'd2;

  // Difference of two unsigned samples, clamped to the signed 16-bit range.
  // Bits [16:15] of the 17-bit difference disagree exactly when it overflows.
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    logic [15:0] r;
    d = {1'b0, a} - {1'b0, b};
    case (d[16:15])
      2'b01:   r = 16'h7FFF;
      2'b10:   r = 16'h8000;
      default: r = d[15:0];
    endcase
    return r;
  endfunction

  logic [0:0]                      w_state_r, w_next_s;
  logic [1:0]                      r_state_r, r_next_s;
  logic [7:0]                      ch_r;
  logic [ADC_CHANEL*DATAWIDTH-1:0] adc_snap_r, base_snap_r;
  logic [15:0]                     frame_cnt_r, drop_cnt_r;
  logic                            busy_r, req_r;
  logic [31:0]                     mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0]               wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]                   level_r;
  logic [31:0]                     tx_data_r;
  logic [15:0]                     n_r, cnt_r;

  logic        space_ok_s, accept_s, drop_s, push_s, pop_s, last_ch_s, req_ok_s;
  logic [31:0] push_word_s;

  assign space_ok_s = (FIFO_DEPTH - int'(level_r)) >= ADC_CHANEL;
  assign accept_s   = adc_valid && (w_state_r == W_IDLE) && cfg_fifo_wr_en && space_ok_s;
  assign drop_s     = adc_valid && cfg_fifo_wr_en && !accept_s;
  assign push_s     = (w_state_r == W_PACK);
  assign last_ch_s  = (ch_r == 8'(ADC_CHANEL - 1));
  assign push_word_s = {ch_r, frame_cnt_r[7:0],
                        sat16(adc_snap_r[int'(ch_r)*DATAWIDTH +: DATAWIDTH],
                              base_snap_r[int'(ch_r)*DATAWIDTH +: DATAWIDTH])};
  // Reader only pops while a packet is in progress; an empty FIFO is never popped.
  assign pop_s    = udp.udp_rd_en && (r_state_r != R_IDLE) && (level_r != LW'(0));
  assign req_ok_s = cfg_udp_tx_enable && (cfg_tx_data_num != 16'd0) &&
                    (int'(cfg_tx_data_num) <= FIFO_DEPTH) &&
                    (int'(level_r) >= int'(cfg_tx_data_num));

  // Writer next state: wait for an accepted frame, then pack every channel.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (accept_s) w_next_s = W_PACK;
        else          w_next_s = W_IDLE;
      end
      W_PACK: begin
        if (last_ch_s) w_next_s = W_IDLE;
        else           w_next_s = W_PACK;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Writer state, input snapshot, channel index and frame/drop counters.
  always_ff @(posedge rib_clk or negedge rib_rst_n) begin
    if (!rib_rst_n) begin
      w_state_r   <= W_IDLE;
      busy_r      <= 1'b0;
      ch_r        <= 8'd0;
      adc_snap_r  <= '0;
      base_snap_r <= '0;
      frame_cnt_r <= 16'd0;
      drop_cnt_r  <= 16'd0;
    end else begin
      w_state_r <= w_next_s;
      busy_r    <= (w_next_s == W_PACK);
      if (accept_s) begin
        adc_snap_r  <= adc_value;
        base_snap_r <= baseline_rib_data;
        ch_r        <= 8'd0;
      end else if (push_s) begin
        ch_r <= ch_r + 8'd1;
      end
      if (push_s && last_ch_s) frame_cnt_r <= frame_cnt_r + 16'd1;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge rib_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_word_s;
  end

  // FIFO pointers, fill level and registered read data.
  always_ff @(posedge rib_clk or negedge rib_rst_n) begin
    if (!rib_rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      level_r   <= '0;
      tx_data_r <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + ADDR_W'(1);
        tx_data_r <= mem_r[rd_ptr_r];
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Reader next state: request once a packet is buffered, then count N reads.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (req_ok_s) r_next_s = R_REQ;
        else          r_next_s = R_IDLE;
      end
      R_REQ: begin
        if (udp.udp_rd_en) r_next_s = (n_r == 16'd1) ? R_IDLE : R_SEND;
        else               r_next_s = R_REQ;
      end
      R_SEND: begin
        if (udp.udp_rd_en && ((cnt_r + 16'd1) == n_r)) r_next_s = R_IDLE;
        else                                            r_next_s = R_SEND;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Reader state, latched packet length, word count and request flag.
  always_ff @(posedge rib_clk or negedge rib_rst_n) begin
    if (!rib_rst_n) begin
      r_state_r <= R_IDLE;
      req_r     <= 1'b0;
      n_r       <= 16'd0;
      cnt_r     <= 16'd0;
    end else begin
      r_state_r <= r_next_s;
      req_r     <= (r_next_s != R_IDLE);
      if ((r_state_r == R_IDLE) && req_ok_s) n_r <= cfg_tx_data_num;
      if (udp.udp_rd_en && (r_state_r == R_REQ))       cnt_r <= 16'd1;
      else if (udp.udp_rd_en && (r_state_r == R_SEND)) cnt_r <= cnt_r + 16'd1;
    end
  end

  assign udp.udp_tx_req  = req_r;
  assign udp.udp_tx_data = tx_data_r;
  assign fifo_level      = level_r;
  assign frame_cnt       = frame_cnt_r;
  assign drop_cnt        = drop_cnt_r;
  assign packer_busy     = busy_r;

endmodule
